dm_arbiter: RTL and testbench

- Shares the single-port 8-bit data memory between two requesters: port 0 is the CPU load/store path, port 1 is the DMA/program-loader path.
- Arbitrates per cycle and supports a bounded lock for multi-beat bursts.
- Drives the memory's DM_w_en, DM_r_en, addr and DM_w_data, and returns registered read data to the granted requester.

---
 rtl/dm_arb_pkg.sv | 17 +
 rtl/dm_arb_pick.sv | 30 +++
 rtl/dm_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dm_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: owner state encoding,
// port indices and default bus widths.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int PORT0  = 0;
    localparam int PORT1  = 1;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

endpackage

// File: rtl/dm_arb_pick.sv
// Two-way combinational picker. An owner takes the grant exclusively; with no owner,
// last = 1 lets port 0 win a contention and last = 0 lets port 1 win.
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    input  arb_state_e state,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (state)
            OWN0: gnt[PORT0] = req0;
            OWN1: gnt[PORT1] = req1;
            default: begin
                if (req0 && req1) begin
                    if (last) gnt[PORT0] = 1'b1;
                    else      gnt[PORT1] = 1'b1;
                end else begin
                    gnt[PORT0] = req0;
                    gnt[PORT1] = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU (port 0) and DMA (port 1).
// Round-robin by default; defining DM_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          DM_w_en,
    output logic          DM_r_en,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] DM_w_data,
    input  logic [DW-1:0] o_DM_data,
    output logic [1:0]    dbg_state
);

    localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

    arb_state_e    state_q, state_d;
    logic [7:0]    lock_cnt_q, lock_cnt_d, cnt_inc;
    logic [1:0]    pick_gnt, gnt;
    logic          last_eff;
    logic          forced_break, fb_port;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    dm_arb_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last_eff),
        .state (state_q),
        .gnt   (pick_gnt)
    );

    // Grants are masked during reset so nothing reaches the memory in the reset cycle.
    assign gnt       = rst ? 2'b00 : pick_gnt;
    assign gnt0      = gnt[PORT0];
    assign gnt1      = gnt[PORT1];
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign dbg_state = state_q;

    always_comb begin
        DM_w_en   = 1'b0;
        DM_r_en   = 1'b0;
        addr      = '0;
        DM_w_data = '0;
        if (gnt[PORT0]) begin
            addr      = addr0;
            DM_w_en   = we0;
            DM_r_en   = ~we0;
            DM_w_data = we0 ? wdata0 : '0;
        end else if (gnt[PORT1]) begin
            addr      = addr1;
            DM_w_en   = we1;
            DM_r_en   = ~we1;
            DM_w_data = we1 ? wdata1 : '0;
        end
    end

    // lock_cnt counts owned beats; the beat that brings it to LOCK_MAX is the last one.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        forced_break = 1'b0;
        fb_port      = 1'b0;
        cnt_inc      = lock_cnt_q + 8'd1;
        case (state_q)
            IDLE: begin
                if (gnt[PORT0] && lock0) begin
                    if (LOCK_MAX > 8'd1) begin
                        state_d    = OWN0;
                        lock_cnt_d = 8'd1;
                    end else begin
                        forced_break = 1'b1;
                        fb_port      = 1'b0;
                    end
                end else if (gnt[PORT1] && lock1) begin
                    if (LOCK_MAX > 8'd1) begin
                        state_d    = OWN1;
                        lock_cnt_d = 8'd1;
                    end else begin
                        forced_break = 1'b1;
                        fb_port      = 1'b1;
                    end
                end
            end
            OWN0: begin
                lock_cnt_d = cnt_inc;
                if (!lock0) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (cnt_inc >= LOCK_MAX) begin
                    state_d      = IDLE;
                    lock_cnt_d   = '0;
                    forced_break = 1'b1;
                    fb_port      = 1'b0;
                end
            end
            OWN1: begin
                lock_cnt_d = cnt_inc;
                if (!lock1) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (cnt_inc >= LOCK_MAX) begin
                    state_d      = IDLE;
                    lock_cnt_d   = '0;
                    forced_break = 1'b1;
                    fb_port      = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        rvalid0_d = gnt[PORT0] & ~we0;
        rvalid1_d = gnt[PORT1] & ~we1;
        rdata0_d  = rvalid0_d ? o_DM_data : rdata0_q;
        rdata1_d  = rvalid1_d ? o_DM_data : rdata1_q;
    end

`ifdef DM_ARB_FIXED_PRIO_EN
    // After port 0 is forced off a lock, port 1 gets exactly one contention.
    logic yield_q, yield_d;

    always_comb begin
        yield_d = forced_break & ~fb_port;
    end

    assign last_eff = ~yield_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) yield_q <= 1'b0;
        else     yield_q <= yield_d;
    end
`else
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (forced_break)  last_d = fb_port;
        else if (|gnt)     last_d = gnt[PORT1];
    end

    assign last_eff = last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural owner/beat/last-winner model.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int AW          = 8;
    localparam int DW          = 8;
    localparam int TB_MAX_LOCK = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          DM_w_en, DM_r_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] DM_w_data, o_DM_data;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    dm_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(TB_MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .DM_w_en(DM_w_en), .DM_r_en(DM_r_en), .addr(addr), .DM_w_data(DM_w_data),
        .o_DM_data(o_DM_data), .dbg_state(dbg_state)
    );

    // ---------------- memory (environment) ----------------
    logic [DW-1:0] mem [256];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a  = '0;
    logic [DW-1:0] pre_d  = '0;

    assign o_DM_data = mem[addr];

    always @(posedge clk) begin
        if (pre_we)       mem[pre_a] <= pre_d;
        else if (DM_w_en) mem[addr]  <= DM_w_data;
    end

    // ---------------- behavioural model ----------------
    logic [DW-1:0] exp_mem [256];
    int            own    = -1;   // -1: nobody owns, else owning port
    int            beats  = 0;    // owned beats so far
    int            last_w = 1;    // port that won most recently
    bit            yld    = 1'b0;
    bit            exp_rv0 = 1'b0, exp_rv1 = 1'b0;
    logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
    int            mg, cg;

    function automatic int model_grant();
        if (rst)      return -1;
        if (own == 0) return req0 ? 0 : -1;
        if (own == 1) return req1 ? 1 : -1;
        if (req0 && req1) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            return yld ? 1 : 0;
`else
            return (last_w == 0) ? 1 : 0;
`endif
        end
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            own = -1; beats = 0; last_w = 1; yld = 1'b0;
            exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
            if (pre_we) exp_mem[pre_a] = pre_d;
        end else begin
            mg = model_grant();
            exp_rv0 = (mg == 0) && !we0;
            exp_rv1 = (mg == 1) && !we1;
            if (exp_rv0) exp_rd0 = exp_mem[addr0];
            if (exp_rv1) exp_rd1 = exp_mem[addr1];
            if (mg == 0 && we0) exp_mem[addr0] = wdata0;
            if (mg == 1 && we1) exp_mem[addr1] = wdata1;
            yld = 1'b0;
            if (own < 0) begin
                if (mg >= 0) begin
                    last_w = mg;
                    if ((mg == 0) ? lock0 : lock1) begin
                        if (TB_MAX_LOCK > 1) begin
                            own = mg; beats = 1;
                        end else begin
                            yld = (mg == 0);
                        end
                    end
                end
            end else begin
                beats = beats + 1;
                if (!((own == 0) ? lock0 : lock1)) begin
                    own = -1;
                end else if (beats >= TB_MAX_LOCK) begin
                    last_w = own;
                    yld = (own == 0);
                    own = -1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        cg     = model_grant();
        e_we   = (cg == 0) ? we0 : (cg == 1) ? we1 : 1'b0;
        e_addr = (cg == 0) ? addr0 : (cg == 1) ? addr1 : '0;
        e_wd   = !e_we ? '0 : (cg == 0) ? wdata0 : wdata1;
        check("cmp_gnt0", 32'(gnt0), 32'(cg == 0));
        check("cmp_gnt1", 32'(gnt1), 32'(cg == 1));
        check("cmp_w_en", 32'(DM_w_en), 32'(e_we));
        check("cmp_r_en", 32'(DM_r_en), 32'((cg >= 0) && !e_we));
        check("cmp_addr", 32'(addr), 32'(e_addr));
        check("cmp_wdata", 32'(DM_w_data), 32'(e_wd));
        check("cmp_rvalid0", 32'(rvalid0), 32'(exp_rv0));
        check("cmp_rvalid1", 32'(rvalid1), 32'(exp_rv1));
        check("cmp_rdata0", 32'(rdata0), 32'(exp_rd0));
        check("cmp_rdata1", 32'(rdata1), 32'(exp_rd1));
        check("cmp_state", 32'(dbg_state),
              (own < 0) ? 32'(IDLE) : (own == 0) ? 32'(OWN0) : 32'(OWN1));
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0; addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] old31;
        logic          g0s, g1s;
        int            errs;
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pre_a  = 8'(i);
            pre_d  = (i == 16) ? 8'h5A : (i == 48) ? 8'hA5 : 8'($urandom_range(0, 255));
            pre_we = 1'b1;
            tick();
        end
        pre_we = 1'b0;
        mid();
        check("rst_rvalid0", 32'(rvalid0), 0);
        check("rst_rdata0", 32'(rdata0), 0);
        check("rst_gnt", 32'({gnt1, gnt0}), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        tick();
        rst = 1'b0;

        // idle: nothing driven
        repeat (5) begin
            mid();
            check("idle_en", 32'({DM_w_en, DM_r_en}), 0);
            check("idle_addr", 32'(addr), 0);
            check("idle_gnt_rv", 32'({gnt1, gnt0, rvalid1, rvalid0}), 0);
            tick();
        end

        // single read
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        mid();
        check("rd_gnt0", 32'(gnt0), 1);
        check("rd_r_en", 32'(DM_r_en), 1);
        check("rd_addr", 32'(addr), 32'h10);
        tick();
        req0 = 1'b0;
        mid();
        check("rd_rvalid0", 32'(rvalid0), 1);
        check("rd_rdata0", 32'(rdata0), 32'h5A);
        tick();

        // contention from reset
        reset_pulse();
        req0 = 1'b1; req1 = 1'b1; addr0 = 8'h01; addr1 = 8'h02;
        for (int k = 0; k < 4; k++) begin
            logic exp0;
`ifdef DM_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (k % 2 == 0);
`endif
            mid();
            check("cont_gnt0", 32'(gnt0), 32'(exp0));
            check("cont_gnt1", 32'(gnt1), 32'(!exp0));
            tick();
        end
        idle_inputs();
        tick();

        // lock burst on port 1 while port 0 waits
        for (int b = 0; b < 4; b++) begin
            req1 = 1'b1; we1 = 1'b1; addr1 = 8'(8'h20 + b); wdata1 = 8'(8'hC0 + b);
            lock1 = (b < 3);
            if (b >= 1) begin req0 = 1'b1; we0 = 1'b0; addr0 = 8'h11; end
            mid();
            check("burst_gnt1", 32'(gnt1), 1);
            check("burst_gnt0", 32'(gnt0), 0);
            tick();
        end
        req1 = 1'b0; lock1 = 1'b0;
        mid();
        check("burst_after_gnt0", 32'(gnt0), 1);
        tick();
        idle_inputs();
        tick();

        // forced lock break
        reset_pulse();
        req0 = 1'b1; lock0 = 1'b1; addr0 = 8'h12; req1 = 1'b1; addr1 = 8'h13;
        for (int k = 0; k < TB_MAX_LOCK; k++) begin
            mid();
            check("brk_gnt0", 32'(gnt0), 1);
            check("brk_gnt1", 32'(gnt1), 0);
            tick();
        end
        mid();
        check("brk_next_gnt1", 32'(gnt1), 1);
        check("brk_next_gnt0", 32'(gnt0), 0);
        tick();
        idle_inputs();
        tick();

        // reset in the cycle after a granted read, with a write pending
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
        tick();
        old31 = mem[8'h31];
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h31; wdata0 = ~old31;
        #1;
        check("mid_pre_rvalid0", 32'(rvalid0), 1);
        check("mid_pre_rdata0", 32'(rdata0), 32'hA5);
        rst = 1'b1;
        #1;
        check("mid_rvalid0", 32'(rvalid0), 0);
        check("mid_rdata0", 32'(rdata0), 0);
        check("mid_state", 32'(dbg_state), 32'(IDLE));
        check("mid_w_en", 32'(DM_w_en), 0);
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
        check("mid_no_write", 32'(mem[8'h31]), 32'(old31));

        // random traffic
        g0s = 1'b0; g1s = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!(req0 && !g0s)) begin
                req0 = ($urandom_range(0, 3) != 0); we0 = 1'($urandom_range(0, 1));
                addr0 = 8'($urandom_range(0, 15)); wdata0 = 8'($urandom_range(0, 255));
                lock0 = ($urandom_range(0, 2) == 0);
            end
            if (!(req1 && !g1s)) begin
                req1 = ($urandom_range(0, 3) != 0); we1 = 1'($urandom_range(0, 1));
                addr1 = 8'($urandom_range(0, 15)); wdata1 = 8'($urandom_range(0, 255));
                lock1 = ($urandom_range(0, 1) == 0);
            end
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            @(negedge clk);
            g0s = gnt0; g1s = gnt1;
            tick();
        end
        idle_inputs();
        tick();

        errs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) errs++;
        check("mem_final", 32'(errs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
